// File: rtl/lm75_target.sv
`default_nettype none
// ============================================================================
// Module   : lm75_target
// Brief    : I2C target emulating an LM75 temperature sensor. Decodes bus
//            START/STOP/address, serves pointer/temp/config/THYST/TOS
//            registers and drives the OS comparator output.
// Revision : 1.0 - initial release
// ============================================================================
module lm75_target #(
    parameter logic [6:0]  DEV_ADDR  = 7'b1001000,
    parameter logic [15:0] TOS_RST   = 16'h5000,
    parameter logic [15:0] THYST_RST = 16'h4B00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] temp,
    output logic        os,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8
    } state_t;

    logic        scl_s1_q, scl_s2_q, scl_dly_q;
    logic        sda_s1_q, sda_s2_q, sda_dly_q;
    logic        scl_rise, scl_fall, bus_start, bus_stop;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        rw_q, rw_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic [7:0]  msb_q, msb_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [15:0] thyst_q, thyst_d;
    logic [15:0] tos_q, tos_d;
    logic [15:0] tx_q, tx_d;
    logic        byte_sel_q, byte_sel_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic [8:0]  temp_q, temp_d;
    logic        os_act_q, os_act_d;

    logic [7:0]  rx_byte, cur_byte, next_byte;
    logic [2:0]  bit_idx;
    logic [15:0] reg_rd;
    logic        unused_temp_lsbs;

    // Open-drain: only ever pull low or release
    assign sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign busy = busy_q;
    assign os   = cfg_q[2] ? os_act_q : ~os_act_q;

    assign scl_rise  =  scl_s2_q & ~scl_dly_q;
    assign scl_fall  = ~scl_s2_q &  scl_dly_q;
    assign bus_start =  scl_s2_q &  scl_dly_q &  sda_dly_q & ~sda_s2_q;
    assign bus_stop  =  scl_s2_q &  scl_dly_q & ~sda_dly_q &  sda_s2_q;

    assign rx_byte   = {shreg_q[6:0], sda_s2_q};
    assign cur_byte  = byte_sel_q ? tx_q[7:0]  : tx_q[15:8];
    assign next_byte = byte_sel_q ? tx_q[15:8] : tx_q[7:0];
    // After k bits have been clocked out, the next bit to drive is 7-k
    assign bit_idx   = ~bit_cnt_q[2:0];

    assign unused_temp_lsbs = ^temp[6:0];

    // Bring scl/sda into the clk domain, plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            scl_dly_q <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            sda_dly_q <= 1'b1;
        end else begin
            scl_s1_q  <= scl;
            scl_s2_q  <= scl_s1_q;
            scl_dly_q <= scl_s2_q;
            sda_s1_q  <= sda;
            sda_s2_q  <= sda_s1_q;
            sda_dly_q <= sda_s2_q;
        end
    end

    // Register selected by the pointer, as presented on a read
    always_comb begin
        reg_rd = {temp_q, 7'b0};
        case (ptr_q)
            2'd1:    reg_rd = {cfg_q, cfg_q};
            2'd2:    reg_rd = thyst_q;
            2'd3:    reg_rd = tos_q;
            default: reg_rd = {temp_q, 7'b0};
        endcase
    end

    // Temperature snapshot (frozen in shutdown) and comparator-mode OS
    always_comb begin
        temp_d   = cfg_q[0] ? temp_q : temp[15:7];
        os_act_d = os_act_q;
        if ($signed(temp_d) > $signed(tos_q[15:7])) begin
            os_act_d = 1'b1;
        end else if ($signed(temp_d) < $signed(thyst_q[15:7])) begin
            os_act_d = 1'b0;
        end
    end

    // Bus protocol FSM: bits sampled on scl rise, sda drive changed on scl fall
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        wcnt_d     = wcnt_q;
        msb_d      = msb_q;
        cfg_d      = cfg_q;
        thyst_d    = thyst_q;
        tos_d      = tos_q;
        tx_d       = tx_q;
        byte_sel_d = byte_sel_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;

        if (bus_start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (bus_stop) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = rx_byte[0];
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            bit_cnt_d = 4'd0;
                            if (rw_q) begin
                                tx_d       = reg_rd;
                                byte_sel_d = 1'b0;
                                sda_oe_d   = ~reg_rd[15];
                                state_d    = ST_RDATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_PTR;
                            end
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            ptr_d   = rx_byte[1:0];
                            state_d = ST_PTR_ACK;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            wcnt_d    = 2'd0;
                            state_d   = ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            // ACK goes out now; the received byte takes effect here
                            sda_oe_d = 1'b1;
                            if (wcnt_q != 2'd2) begin
                                wcnt_d = wcnt_q + 2'd1;
                            end
                            case (ptr_q)
                                2'd1: begin
                                    if (wcnt_q == 2'd0) cfg_d = shreg_q;
                                end
                                2'd2: begin
                                    if (wcnt_q == 2'd0)      msb_d   = shreg_q;
                                    else if (wcnt_q == 2'd1) thyst_d = {msb_q, shreg_q[7], 7'b0};
                                end
                                2'd3: begin
                                    if (wcnt_q == 2'd0)      msb_d = shreg_q;
                                    else if (wcnt_q == 2'd1) tos_d = {msb_q, shreg_q[7], 7'b0};
                                end
                                default: begin
                                end
                            endcase
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RACK;
                        end else begin
                            sda_oe_d = ~cur_byte[bit_idx];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        // NACK ends the read; stay released until the next START/STOP
                        if (sda_s2_q) begin
                            state_d = ST_IDLE;
                        end
                    end else if (scl_fall) begin
                        byte_sel_d = ~byte_sel_q;
                        bit_cnt_d  = 4'd0;
                        sda_oe_d   = ~next_byte[7];
                        state_d    = ST_RDATA;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and register file; reset releases sda immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 8'h00;
            rw_q       <= 1'b0;
            ptr_q      <= 2'd0;
            wcnt_q     <= 2'd0;
            msb_q      <= 8'h00;
            cfg_q      <= 8'h00;
            thyst_q    <= THYST_RST;
            tos_q      <= TOS_RST;
            tx_q       <= 16'h0000;
            byte_sel_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            temp_q     <= 9'd0;
            os_act_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            wcnt_q     <= wcnt_d;
            msb_q      <= msb_d;
            cfg_q      <= cfg_d;
            thyst_q    <= thyst_d;
            tos_q      <= tos_d;
            tx_q       <= tx_d;
            byte_sel_q <= byte_sel_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            temp_q     <= temp_d;
            os_act_q   <= os_act_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lm75_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_lm75_target
// Brief    : Directed bench for lm75_target acting as an I2C initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lm75_target;

    localparam int Q = 80;   // quarter SCL period in ns (8 clk)

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        tb_sda_low;
    logic [15:0] temp;
    logic        os;
    logic        busy;
    wire         sda;

    int total = 0;
    int bad   = 0;

    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup pu_sda (sda);

    always #5 clk = ~clk;

    lm75_target dut (
        .clk  (clk),
        .rst  (rst),
        .scl  (scl),
        .sda  (sda),
        .temp (temp),
        .os   (os),
        .busy (busy)
    );

    function automatic logic sda_now();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    // Bus primitives; every bit leaves scl low on exit
    task automatic i2c_start();
        #Q; tb_sda_low = 1'b0;
        #Q; scl = 1'b1;
        #Q; tb_sda_low = 1'b1;
        #Q; scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q; tb_sda_low = 1'b1;
        #Q; scl = 1'b1;
        #Q; tb_sda_low = 1'b0;
        #(2*Q);
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        #Q; tb_sda_low = ~b;
        #Q; scl = 1'b1;
        #Q; r = sda_now();
        #Q; scl = 1'b0;
    endtask

    task automatic i2c_wbyte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, ack);
    endtask

    task automatic i2c_rbyte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(nack, r);
    endtask

    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; tb_sda_low = 1'b0; temp = 16'h0000;
        #40;
        total++; if (os !== 1'b1) begin bad++; $display("FAIL reset_os_in_rst: got %b expected 1", os); end
        rst = 1'b0;
        #40;
        total++; if (sda_now() !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b expected 1", sda_now()); end
        total++; if (os !== 1'b1) begin bad++; $display("FAIL reset_os: got %b expected 1", os); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_os_ramp();
        logic [15:0] ramp [4];
        logic        exp_os [4];
        logic        a0, a1, a2;
        ramp[0] = 16'h4A00; exp_os[0] = 1'b1;
        ramp[1] = 16'h5080; exp_os[1] = 1'b0;
        ramp[2] = 16'h4C00; exp_os[2] = 1'b0;
        ramp[3] = 16'h4A80; exp_os[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            temp = ramp[i];
            #50;
            total++; if (os !== exp_os[i]) begin bad++; $display("FAIL os_ramp[%0d]: got %b expected %b", i, os, exp_os[i]); end
        end
        i2c_start(); i2c_wbyte(8'h90, a0); i2c_wbyte(8'h01, a1); i2c_wbyte(8'h04, a2); i2c_stop();
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL cfg04_acks: got %b expected 000", {a0, a1, a2}); end
        #50;
        total++; if (os !== 1'b0) begin bad++; $display("FAIL os_pol_low_temp: got %b expected 0", os); end
        temp = 16'h5080; #50;
        total++; if (os !== 1'b1) begin bad++; $display("FAIL os_pol_hot: got %b expected 1", os); end
        i2c_start(); i2c_wbyte(8'h90, a0); i2c_wbyte(8'h01, a1); i2c_wbyte(8'h00, a2); i2c_stop();
        #50;
        total++; if (os !== 1'b0) begin bad++; $display("FAIL os_cfg00_hot: got %b expected 0", os); end
        temp = 16'h1980; #50;
        total++; if (os !== 1'b1) begin bad++; $display("FAIL os_cool_clear: got %b expected 1", os); end
    endtask

    task automatic test_temp_read();
        logic       a0, a1, a2;
        logic [7:0] b0, b1;
        temp = 16'h1980;
        i2c_start(); i2c_wbyte(8'h90, a0); i2c_wbyte(8'h00, a1);
        i2c_start(); i2c_wbyte(8'h91, a2);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL tread_acks: got %b expected 000", {a0, a1, a2}); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tread_busy: got %b expected 1", busy); end
        i2c_rbyte(1'b0, b0); i2c_rbyte(1'b1, b1);
        total++; if (b0 !== 8'h19) begin bad++; $display("FAIL tread_msb: got %h expected 19", b0); end
        total++; if (b1 !== 8'h80) begin bad++; $display("FAIL tread_lsb: got %h expected 80", b1); end
        #Q;
        total++; if (sda_now() !== 1'b1) begin bad++; $display("FAIL tread_release: got %b expected 1", sda_now()); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tread_busy_nack: got %b expected 1", busy); end
        i2c_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tread_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_reg_write();
        logic [3:0] acks;
        logic       a;
        logic [7:0] b0, b1;
        i2c_start(); i2c_wbyte(8'h90, acks[3]); i2c_wbyte(8'h03, acks[2]);
        i2c_wbyte(8'h5A, acks[1]); i2c_wbyte(8'hFF, acks[0]); i2c_stop();
        total++; if (acks !== 4'b0000) begin bad++; $display("FAIL tos_wr_acks: got %b expected 0000", acks); end
        i2c_start(); i2c_wbyte(8'h91, a); i2c_rbyte(1'b0, b0); i2c_rbyte(1'b1, b1); i2c_stop();
        total++; if ({a, b0, b1} !== {1'b0, 16'h5A80}) begin bad++; $display("FAIL tos_readback: got %b %h%h expected 0 5a80", a, b0, b1); end
        i2c_start(); i2c_wbyte(8'h90, a); i2c_wbyte(8'h02, a);
        i2c_start(); i2c_wbyte(8'h91, a); i2c_rbyte(1'b0, b0); i2c_rbyte(1'b1, b1); i2c_stop();
        total++; if ({b0, b1} !== 16'h4B00) begin bad++; $display("FAIL thyst_reset_read: got %h%h expected 4b00", b0, b1); end
    endtask

    task automatic test_addr_mismatch();
        logic a;
        i2c_start(); i2c_wbyte(8'h92, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL mismatch_nack: got %b expected 1", a); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mismatch_busy: got %b expected 0", busy); end
        i2c_start(); i2c_wbyte(8'h90, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL match_ack: got %b expected 0", a); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL match_busy: got %b expected 1", busy); end
        i2c_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL match_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_shutdown();
        logic       a;
        logic [7:0] b0, b1;
        temp = 16'h1900; #50;
        i2c_start(); i2c_wbyte(8'h90, a); i2c_wbyte(8'h01, a); i2c_wbyte(8'h01, a); i2c_stop();
        temp = 16'h3200; #50;
        i2c_start(); i2c_wbyte(8'h90, a); i2c_wbyte(8'h00, a);
        i2c_start(); i2c_wbyte(8'h91, a); i2c_rbyte(1'b0, b0); i2c_rbyte(1'b1, b1); i2c_stop();
        total++; if ({b0, b1} !== 16'h1900) begin bad++; $display("FAIL shutdown_hold: got %h%h expected 1900", b0, b1); end
    endtask

    task automatic test_wrap_and_reset();
        logic       a, r;
        logic [7:0] got [4];
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hE7; exp_b[1] = 8'h00; exp_b[2] = 8'hE7; exp_b[3] = 8'h00;
        i2c_start(); i2c_wbyte(8'h90, a); i2c_wbyte(8'h01, a); i2c_wbyte(8'h00, a); i2c_stop();
        temp = 16'hE700; #50;
        i2c_start(); i2c_wbyte(8'h90, a); i2c_wbyte(8'h00, a);
        i2c_start(); i2c_wbyte(8'h91, a);
        for (int i = 0; i < 4; i++) i2c_rbyte((i == 3), got[i]);
        i2c_stop();
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== exp_b[i]) begin bad++; $display("FAIL wrap_byte[%0d]: got %h expected %h", i, got[i], exp_b[i]); end
        end
        // Partial read, then reset while the target is holding sda low
        i2c_start(); i2c_wbyte(8'h91, a);
        for (int i = 0; i < 3; i++) i2c_bit(1'b1, r);
        #Q;
        total++; if (sda_now() !== 1'b0) begin bad++; $display("FAIL rst_pre_drive: got %b expected 0", sda_now()); end
        rst = 1'b1;
        #1;
        total++; if (sda_now() !== 1'b1) begin bad++; $display("FAIL rst_async_release: got %b expected 1", sda_now()); end
        #29;
        rst = 1'b0;
        #Q; scl = 1'b1; #(2*Q);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        i2c_start(); i2c_wbyte(8'h91, a); i2c_rbyte(1'b0, got[0]); i2c_rbyte(1'b1, got[1]); i2c_stop();
        total++; if ({a, got[0], got[1]} !== {1'b0, 16'hE700}) begin bad++; $display("FAIL post_rst_read: got %b %h%h expected 0 e700", a, got[0], got[1]); end
    endtask

    initial begin
        test_reset();
        test_os_ramp();
        test_temp_read();
        test_reg_write();
        test_addr_mismatch();
        test_shutdown();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
